// File: rtl/rs_issue_select_if.sv
// Bundle of the reservation-station side and execute-latch side signals of rs_issue_select.
// master drives the stations and the functional-unit status; slave is the selector itself.
interface rs_issue_select_if #(
  parameter int NUM_RS     = 4,
  parameter int ROBsize    = 8,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
);
  logic [NUM_RS-1:0]            rsReady_i;
  logic [NUM_RS-1:0]            rsBusy_i;
  logic [NUM_RS*64-1:0]         rsVal1_i;
  logic [NUM_RS*64-1:0]         rsVal2_i;
  logic [NUM_RS*10-1:0]         rsCommands_i;
  logic [NUM_RS*ROBsizeLog-1:0] rsTag_i;
  logic                         fuStall_i;
  logic                         flush_i;
  logic [NUM_RS-1:0]            rsStall_o;
  logic                         execValid_o;
  logic [63:0]                  execVal1_o;
  logic [63:0]                  execVal2_o;
  logic [9:0]                   execCommands_o;
  logic [ROBsizeLog-1:0]        execTag_o;
  logic [$clog2(NUM_RS)-1:0]    execSrc_o;
  logic [$clog2(NUM_RS+1)-1:0]  busyCount_o;

  modport master (
    output rsReady_i, rsBusy_i, rsVal1_i, rsVal2_i, rsCommands_i, rsTag_i,
    output fuStall_i, flush_i,
    input  rsStall_o, execValid_o, execVal1_o, execVal2_o, execCommands_o,
    input  execTag_o, execSrc_o, busyCount_o
  );

  modport slave (
    input  rsReady_i, rsBusy_i, rsVal1_i, rsVal2_i, rsCommands_i, rsTag_i,
    input  fuStall_i, flush_i,
    output rsStall_o, execValid_o, execVal1_o, execVal2_o, execCommands_o,
    output execTag_o, execSrc_o, busyCount_o
  );
endinterface

// File: rtl/rs_issue_select.sv
// Round-robin issue selector: grants one ready reservation station per cycle and
// captures its operands into a one-entry execute latch that holds under FU back-pressure.
module rs_issue_select #(
  parameter int NUM_RS     = 4,
  parameter int ROBsize    = 8,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  rs_issue_select_if.slave  bus
);
  localparam int PTR_W = $clog2(NUM_RS);
  localparam int CNT_W = $clog2(NUM_RS + 1);

  logic                  r_exec_valid;
  logic [63:0]           r_exec_val1;
  logic [63:0]           r_exec_val2;
  logic [9:0]            r_exec_cmd;
  logic [ROBsizeLog-1:0] r_exec_tag;
  logic [PTR_W-1:0]      r_exec_src;
  logic [CNT_W-1:0]      r_busy_count;
  logic [PTR_W-1:0]      r_rr_ptr;

  logic                  w_can_accept;
  logic                  w_grant;
  logic [PTR_W-1:0]      w_grant_idx;
  logic [NUM_RS-1:0]     w_grant_oh;
  logic [63:0]           w_sel_val1;
  logic [63:0]           w_sel_val2;
  logic [9:0]            w_sel_cmd;
  logic [ROBsizeLog-1:0] w_sel_tag;

  // Station index (base + off) modulo NUM_RS, valid for off < NUM_RS.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    s = (s >= NUM_RS) ? (s - NUM_RS) : s;
    return s[PTR_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_RS-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      cnt = cnt + CNT_W'(v[k]);
    end
    return cnt;
  endfunction

  assign w_can_accept = ~r_exec_valid | ~bus.fuStall_i;
  // Reset gating keeps every station stalled while the selector is held in reset.
  assign w_grant      = reset_i & w_can_accept & ~bus.flush_i & (|bus.rsReady_i);

  // Circular priority search: scanning downward lets the candidate nearest rrPtr win.
  always_comb begin
    w_grant_idx = r_rr_ptr;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      w_grant_idx = bus.rsReady_i[wrap_add(r_rr_ptr, i)] ? wrap_add(r_rr_ptr, i) : w_grant_idx;
    end
  end

  // One-hot grant vector and AND-OR operand mux of the granted station.
  always_comb begin
    w_grant_oh = '0;
    w_sel_val1 = '0;
    w_sel_val2 = '0;
    w_sel_cmd  = '0;
    w_sel_tag  = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      w_grant_oh[k] = w_grant & (w_grant_idx == PTR_W'(k));
      w_sel_val1    = w_sel_val1 | ({64{w_grant_oh[k]}} & bus.rsVal1_i[64*k +: 64]);
      w_sel_val2    = w_sel_val2 | ({64{w_grant_oh[k]}} & bus.rsVal2_i[64*k +: 64]);
      w_sel_cmd     = w_sel_cmd  | ({10{w_grant_oh[k]}} & bus.rsCommands_i[10*k +: 10]);
      w_sel_tag     = w_sel_tag  | ({ROBsizeLog{w_grant_oh[k]}} & bus.rsTag_i[ROBsizeLog*k +: ROBsizeLog]);
    end
  end

  // Execute latch, round-robin pointer and busy-count registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_exec_valid <= 1'b0;
      r_exec_val1  <= 64'd0;
      r_exec_val2  <= 64'd0;
      r_exec_cmd   <= 10'd0;
      r_exec_tag   <= '0;
      r_exec_src   <= '0;
      r_busy_count <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_busy_count <= popcount(bus.rsBusy_i);
      if (bus.flush_i) begin
        r_exec_valid <= 1'b0;
      end else if (w_grant) begin
        r_exec_valid <= 1'b1;
        r_exec_val1  <= w_sel_val1;
        r_exec_val2  <= w_sel_val2;
        r_exec_cmd   <= w_sel_cmd;
        r_exec_tag   <= w_sel_tag;
        r_exec_src   <= w_grant_idx;
        r_rr_ptr     <= wrap_add(w_grant_idx, 1);
      end else if (w_can_accept) begin
        r_exec_valid <= 1'b0;
      end else begin
        r_exec_valid <= r_exec_valid;
      end
    end
  end

  assign bus.rsStall_o      = ~w_grant_oh;
  assign bus.execValid_o    = r_exec_valid;
  assign bus.execVal1_o     = r_exec_val1;
  assign bus.execVal2_o     = r_exec_val2;
  assign bus.execCommands_o = r_exec_cmd;
  assign bus.execTag_o      = r_exec_tag;
  assign bus.execSrc_o      = r_exec_src;
  assign bus.busyCount_o    = r_busy_count;
endmodule
